// File: rtl/debug_run_controller_pkg.sv
// Shared command opcodes, state codes and field widths for the debug run controller.
// Revision 1.0 - initial release.
`default_nettype none

package debug_run_controller_pkg;

   localparam int CMD_W   = 3;
   localparam int STATE_W = 3;

   localparam logic [CMD_W-1:0] CMD_NOP     = 3'd0;
   localparam logic [CMD_W-1:0] CMD_RUN     = 3'd1;
   localparam logic [CMD_W-1:0] CMD_STEP    = 3'd2;
   localparam logic [CMD_W-1:0] CMD_HALT    = 3'd3;
   localparam logic [CMD_W-1:0] CMD_CLR_CNT = 3'd4;
   localparam logic [CMD_W-1:0] CMD_SET_BP  = 3'd5;

   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ST_RUN    = 3'd1;
   localparam logic [STATE_W-1:0] ST_STEP   = 3'd2;
   localparam logic [STATE_W-1:0] ST_HALTED = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/debug_cycle_counter.sv
// Enabled-cycle counter with synchronous clear; wraps silently at 2^NB_BITS.
// Revision 1.0 - initial release.
`default_nettype none

module debug_cycle_counter #(
   parameter int NB_BITS = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_enb,
   input  logic               i_clr,
   output logic [NB_BITS-1:0] o_cnt
);

   logic [NB_BITS-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_enb) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/debug_run_controller.sv
// Run-control sequencer driving the global pipeline enable (run / N-step / halt / done).
// Optional PC breakpoint enabled by macro DEBUG_BREAKPOINT_EN. Revision 1.0 - initial release.
`default_nettype none

module debug_run_controller
   import debug_run_controller_pkg::*;
#(
   parameter int NB_BITS  = 32,
   parameter int NB_CMD   = CMD_W,
   parameter int NB_STATE = STATE_W
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_cmd_valid,
   input  logic [NB_CMD-1:0]   i_cmd,
   input  logic [NB_BITS-1:0]  i_cmd_arg,
   input  logic                i_halt_inst,
   input  logic [NB_BITS-1:0]  i_pc,
   output logic                o_pipe_enb,
   output logic [NB_STATE-1:0] o_state,
   output logic [NB_BITS-1:0]  o_cycle_cnt,
   output logic                o_cmd_err,
   output logic                o_done
);

   logic [NB_STATE-1:0] r_state;
   logic [NB_STATE-1:0] w_state_next;
   logic [NB_BITS-1:0]  r_step_cnt;
   logic [NB_BITS-1:0]  w_step_cnt_next;
   logic                r_pipe_enb;
   logic                r_cmd_err;
   logic                r_done;
   logic                w_cmd_legal;
   logic                w_accept;
   logic                w_clr_cnt;
   logic                w_bp_hit;

`ifdef DEBUG_BREAKPOINT_EN
   logic [NB_BITS-1:0] r_bp_addr;
   logic               r_bp_valid;
   logic               r_bp_skip;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bp_addr  <= '0;
         r_bp_valid <= 1'b0;
         r_bp_skip  <= 1'b0;
      end else begin
         if (w_accept && (i_cmd == CMD_SET_BP)) begin
            r_bp_addr  <= i_cmd_arg;
            r_bp_valid <= 1'b1;
         end
         // Resuming from a breakpoint must be able to step off the matching PC.
         r_bp_skip <= (r_state == ST_HALTED) && w_accept && (i_cmd == CMD_RUN);
      end
   end

   assign w_bp_hit = (r_state == ST_RUN) && r_pipe_enb && r_bp_valid && !r_bp_skip
                     && (i_pc == r_bp_addr);
`else
   logic w_unused_pc;
   assign w_unused_pc = ^i_pc;
   assign w_bp_hit    = 1'b0;
`endif

   always_comb begin
      w_cmd_legal = 1'b1;
      if (i_cmd != CMD_NOP) begin
         case (r_state)
            ST_IDLE, ST_HALTED: begin
               case (i_cmd)
                  CMD_RUN, CMD_STEP, CMD_HALT, CMD_CLR_CNT: w_cmd_legal = 1'b1;
`ifdef DEBUG_BREAKPOINT_EN
                  CMD_SET_BP:                               w_cmd_legal = 1'b1;
`endif
                  default:                                  w_cmd_legal = 1'b0;
               endcase
            end
            ST_RUN, ST_STEP: w_cmd_legal = (i_cmd == CMD_HALT);
            default:         w_cmd_legal = 1'b0;
         endcase
      end
   end

   assign w_accept  = i_cmd_valid && w_cmd_legal;
   assign w_clr_cnt = w_accept && (i_cmd == CMD_CLR_CNT);

   always_comb begin
      w_state_next    = r_state;
      w_step_cnt_next = r_step_cnt;
      case (r_state)
         ST_IDLE, ST_HALTED: begin
            if (w_accept && (i_cmd == CMD_RUN)) begin
               w_state_next = ST_RUN;
            end else if (w_accept && (i_cmd == CMD_STEP)) begin
               w_state_next    = ST_STEP;
               w_step_cnt_next = (i_cmd_arg == '0) ? NB_BITS'(1) : i_cmd_arg;
            end
         end
         ST_RUN: begin
            if ((w_accept && (i_cmd == CMD_HALT)) || w_bp_hit) begin
               w_state_next = ST_HALTED;
            end
         end
         ST_STEP: begin
            if ((w_accept && (i_cmd == CMD_HALT)) || (r_step_cnt <= NB_BITS'(1))) begin
               w_state_next    = ST_HALTED;
               w_step_cnt_next = '0;
            end else begin
               w_step_cnt_next = r_step_cnt - 1'b1;
            end
         end
         ST_DONE: w_state_next = ST_DONE;
         default: w_state_next = ST_IDLE;
      endcase
      // A retiring halt instruction outranks every command and step expiry.
      if (i_halt_inst && r_pipe_enb) begin
         w_state_next    = ST_DONE;
         w_step_cnt_next = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_step_cnt <= '0;
         r_pipe_enb <= 1'b0;
         r_cmd_err  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_step_cnt <= w_step_cnt_next;
         r_pipe_enb <= (w_state_next == ST_RUN) || (w_state_next == ST_STEP);
         r_cmd_err  <= i_cmd_valid && !w_cmd_legal;
         r_done     <= (w_state_next == ST_DONE);
      end
   end

   debug_cycle_counter #(
      .NB_BITS (NB_BITS)
   ) u_cycle_counter (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_enb (r_pipe_enb),
      .i_clr (w_clr_cnt),
      .o_cnt (o_cycle_cnt)
   );

   assign o_pipe_enb = r_pipe_enb;
   assign o_state    = r_state;
   assign o_cmd_err  = r_cmd_err;
   assign o_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_debug_run_controller.sv
// Scoreboard bench for debug_run_controller: directed scenarios plus randomized command traffic.
// Revision 1.0 - initial release.
`default_nettype none

module tb_debug_run_controller;

`ifdef DEBUG_BREAKPOINT_EN
   localparam bit BP_ON = 1'b1;
`else
   localparam bit BP_ON = 1'b0;
`endif

   logic        clk;
   logic        i_rst;
   logic        i_cmd_valid;
   logic [2:0]  i_cmd;
   logic [31:0] i_cmd_arg;
   logic        i_halt_inst;
   logic [31:0] i_pc;
   logic        o_pipe_enb;
   logic [2:0]  o_state;
   logic [31:0] o_cycle_cnt;
   logic        o_cmd_err;
   logic        o_done;

   debug_run_controller #(
      .NB_BITS  (32),
      .NB_CMD   (3),
      .NB_STATE (3)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_cmd_valid (i_cmd_valid),
      .i_cmd       (i_cmd),
      .i_cmd_arg   (i_cmd_arg),
      .i_halt_inst (i_halt_inst),
      .i_pc        (i_pc),
      .o_pipe_enb  (o_pipe_enb),
      .o_state     (o_state),
      .o_cycle_cnt (o_cycle_cnt),
      .o_cmd_err   (o_cmd_err),
      .o_done      (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          state;
      bit          enb;
      logic [31:0] cnt;
      bit          err;
      bit          done;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: values the outputs must show after the next clock edge.
   int          m_state = 0;
   int unsigned m_steps_left = 0;
   logic [31:0] m_cnt = 0;
   bit          m_err = 0;
   bit          m_done = 0;
   bit          m_bp_valid = 0;
   logic [31:0] m_bp = 0;
   bit          m_skip = 0;

   function automatic bit legal(int st, int c);
      if (c == 0) return 1'b1;
      if (st == 0 || st == 3) return (c >= 1 && c <= 4) || (c == 5 && BP_ON);
      if (st == 1 || st == 2) return c == 3;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("state",    32'(o_state),    32'(e.state));
         chk("pipe_enb", 32'(o_pipe_enb), 32'(e.enb));
         chk("cycle_cnt", o_cycle_cnt,    e.cnt);
         chk("cmd_err",  32'(o_cmd_err),  32'(e.err));
         chk("done",     32'(o_done),     32'(e.done));
      end
   end

   task automatic drive(input bit rst, input bit v, input int c, input logic [31:0] arg,
                        input bit hi, input logic [31:0] pc);
      bit   running, act, hit, next_skip;
      int   ns;
      exp_t e;
      @(negedge clk);
      i_rst       = rst;
      i_cmd_valid = v;
      i_cmd       = 3'(c);
      i_cmd_arg   = arg;
      i_halt_inst = hi;
      i_pc        = pc;
      if (rst) begin
         m_state = 0; m_steps_left = 0; m_cnt = 0; m_err = 0; m_done = 0;
         m_bp_valid = 0; m_bp = 0; m_skip = 0;
      end else begin
         running   = (m_state == 1 || m_state == 2);
         act       = v && c != 0 && legal(m_state, c);
         m_err     = v && !legal(m_state, c);
         hit       = BP_ON && m_state == 1 && m_bp_valid && !m_skip && pc == m_bp;
         next_skip = 1'b0;
         ns        = m_state;
         if (act && c == 4) m_cnt = 0;
         else if (running)  m_cnt = m_cnt + 1;
         if (running && hi) begin
            ns = 4;
         end else if (m_state == 0 || m_state == 3) begin
            if (act && c == 1) begin
               ns = 1;
               next_skip = (m_state == 3);
            end else if (act && c == 2) begin
               ns = 2;
               m_steps_left = (arg == 0) ? 1 : arg;
            end else if (act && c == 5) begin
               m_bp = arg;
               m_bp_valid = 1'b1;
            end
         end else if (m_state == 1) begin
            if ((act && c == 3) || hit) ns = 3;
         end else if (m_state == 2) begin
            if (act && c == 3) begin
               ns = 3;
            end else begin
               m_steps_left--;
               if (m_steps_left == 0) ns = 3;
            end
         end
         m_state = ns;
         m_skip  = next_skip;
         m_done  = m_done || (ns == 4);
      end
      e.state = m_state;
      e.enb   = (m_state == 1 || m_state == 2);
      e.cnt   = m_cnt;
      e.err   = m_err;
      e.done  = m_done;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic cmd(input int c, input logic [31:0] arg);
      drive(0, 1, c, arg, 0, 0);
   endtask

   initial begin
      i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = '0; i_cmd_arg = '0;
      i_halt_inst = 1'b0; i_pc = '0;

      for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 0);
      idle(6);
      cmd(2, 3);                      // STEP 3
      idle(6);
      cmd(2, 0);                      // STEP 0 acts as one step
      idle(4);
      cmd(1, 0);                      // RUN
      idle(4);
      cmd(2, 5);                      // STEP while running: rejected
      idle(14);
      cmd(3, 0);                      // HALT
      idle(3);
      cmd(4, 0);                      // CLR_CNT
      idle(3);
      cmd(1, 0);
      idle(3);
      drive(0, 1, 3, 0, 1, 0);        // halt instruction together with HALT
      idle(2);
      cmd(1, 0);                      // RUN in DONE: rejected
      idle(3);
      drive(1, 0, 0, 0, 0, 0);
      idle(2);
      cmd(2, 100);
      idle(40);
      drive(1, 0, 0, 0, 0, 0);        // reset mid-step
      idle(2);
      cmd(7, 0);                      // illegal opcode
      cmd(6, 0);
      idle(2);

      // Breakpoint scenario (SET_BP rejected when the feature is absent).
      cmd(5, 32'h10);
      idle(1);
      drive(0, 1, 1, 0, 0, 32'h0);
      for (int k = 0; k <= 4; k++) drive(0, 0, 0, 0, 0, 32'(4 * k));
      idle(2);
      drive(0, 1, 1, 0, 0, 32'h10);
      for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 0, 32'(32'h10 + 4 * k));
      cmd(3, 0);
      idle(2);

      for (int n = 0; n < 4000; n++) begin
         bit          r, v, hi;
         int          c;
         logic [31:0] arg;
         r   = ($urandom_range(0, 299) == 0) || (m_state == 4 && $urandom_range(0, 9) == 0);
         v   = ($urandom_range(0, 3) == 0);
         c   = $urandom_range(0, 7);
         arg = $urandom_range(0, 1) ? 32'(4 * $urandom_range(0, 8)) : 32'($urandom_range(0, 3));
         hi  = ($urandom_range(0, 199) == 0);
         drive(r, v, c, arg, hi, 32'(4 * $urandom_range(0, 8)));
      end

      idle(2);
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
